// File: rtl/i2c_slave_mem.sv
// I2C target with a DEPTH-byte register file. The first write byte sets the pointer and later
// bytes write with auto-increment. Reads stream from the pointer. Macro I2C_SLAVE_GCALL_EN adds general-call writes.
module i2c_slave_mem #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  parameter int         AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          ack_out
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK} state_t;

  state_t        state_q;
  logic [2:0]    scl_q, sda_q;  // [1:0] synchronizer, [2] history
  logic [7:0]    sh_q;
  logic [2:0]    cnt_q;
  logic          full_q, first_q, rw_q, mack_q, sda_oe_q;
  logic [AW-1:0] ptr_q;
  logic [7:0]    mem_q [DEPTH];

  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    sh_d;
  logic [AW-1:0] ptr_d;

  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign sh_d      = {sh_q[6:0], sda_q[1]};
  assign ptr_d     = ptr_q + 1'b1;
  assign sda       = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchronizers reset to the idle-bus level so leaving reset creates no false edges
      scl_q     <= '1;
      sda_q     <= '1;
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      first_q   <= 1'b0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      ptr_q     <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      ack_out   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      scl_q     <= {scl_q[1:0], scl};
      sda_q     <= {sda_q[1:0], sda};
      wr_strobe <= 1'b0;
      if (start_det) begin
        state_q  <= ADDR;
        cnt_q    <= 3'd7;
        full_q   <= 1'b0;
        mack_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        ack_out  <= 1'b0;
        busy     <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        mack_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        ack_out  <= 1'b0;
        busy     <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ADDR, RX_BYTE: begin
            sh_q <= sh_d;
            if (cnt_q == 3'd0) full_q <= 1'b1;
            else cnt_q <= cnt_q - 3'd1;
          end
          TX_ACK: begin
            if (sda_q[1]) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              ptr_q  <= ptr_d;
              mack_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          ADDR: if (full_q) begin
            full_q <= 1'b0;
            rw_q   <= sh_q[0];
            if (sh_q[7:1] == SLAVE_ADDR) begin
              state_q  <= ADDR_ACK;
              sda_oe_q <= 1'b1;
              ack_out  <= 1'b1;
              busy     <= 1'b1;
              first_q  <= 1'b1;
            end
`ifdef I2C_SLAVE_GCALL_EN
            else if (sh_q == 8'h00) begin
              // General call carries no pointer byte; data lands at mem[0..]
              state_q  <= ADDR_ACK;
              sda_oe_q <= 1'b1;
              ack_out  <= 1'b1;
              busy     <= 1'b1;
              first_q  <= 1'b0;
              ptr_q    <= '0;
            end
`endif
            else state_q <= IDLE;
          end
          ADDR_ACK: begin
            ack_out <= 1'b0;
            cnt_q   <= 3'd7;
            if (rw_q) begin
              state_q  <= TX_BYTE;
              sh_q     <= mem_q[ptr_q];
              sda_oe_q <= ~mem_q[ptr_q][7];
            end else begin
              state_q  <= RX_BYTE;
              sda_oe_q <= 1'b0;
            end
          end
          RX_BYTE: if (full_q) begin
            full_q   <= 1'b0;
            state_q  <= RX_ACK;
            sda_oe_q <= 1'b1;
            ack_out  <= 1'b1;
            if (first_q) ptr_q <= sh_q[AW-1:0];
            else begin
              mem_q[ptr_q] <= sh_q;
              wr_strobe    <= 1'b1;
              wr_addr      <= ptr_q;
              wr_data      <= sh_q;
              ptr_q        <= ptr_d;
            end
          end
          RX_ACK: begin
            state_q  <= RX_BYTE;
            sda_oe_q <= 1'b0;
            ack_out  <= 1'b0;
            first_q  <= 1'b0;
            cnt_q    <= 3'd7;
          end
          TX_BYTE: begin
            if (cnt_q == 3'd0) begin
              state_q  <= TX_ACK;
              sda_oe_q <= 1'b0;
              mack_q   <= 1'b0;
            end else begin
              sh_q     <= {sh_q[6:0], 1'b0};
              sda_oe_q <= ~sh_q[6];
              cnt_q    <= cnt_q - 3'd1;
            end
          end
          TX_ACK: if (mack_q) begin
            mack_q   <= 1'b0;
            state_q  <= TX_BYTE;
            cnt_q    <= 3'd7;
            sh_q     <= mem_q[ptr_q];
            sda_oe_q <= ~mem_q[ptr_q][7];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bus-level bench for i2c_slave_mem: the bench acts as an I2C master with a pulled-up SDA.
module tb_i2c_slave_mem;
  localparam int Q = 200;

  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
  wire        sda;
  logic       wr_strobe, busy, ack_out;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int         checks = 0, errors = 0;
  logic [11:0] wlog[$];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_mem dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .ack_out(ack_out)
  );

  always #10 clk = ~clk;
  always @(negedge clk) if (!rst && wr_strobe) wlog.push_back({wr_addr, wr_data});

  task automatic i2c_start;
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic aout);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    m_low = 1'b0; #Q; scl = 1'b1; #Q; ack = sda; aout = ack_out; #Q; scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b[i] = sda; #Q; scl = 1'b0;
    end
    #Q; m_low = mack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; m_low = 1'b0;
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (sda !== 1'b1)     begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack_out got %b exp 0", ack_out); end
    checks++; if ({wr_strobe, wr_addr, wr_data} !== 13'h0)
      begin errors++; $display("FAIL reset_wr got %b/%h/%h exp 0/0/00", wr_strobe, wr_addr, wr_data); end
  endtask

  task automatic test_write;
    logic a, ao;
    wlog.delete();
    i2c_start();
    write_byte(8'hA0, a, ao);
    checks++; if ({a, ao} !== 2'b01) begin errors++; $display("FAIL wr_addr_ack sda/ack_out got %b%b exp 01", a, ao); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", busy); end
    write_byte(8'h03, a, ao);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack got %b exp 0", a); end
    write_byte(8'h5A, a, ao);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_d0_ack got %b exp 0", a); end
    write_byte(8'hC3, a, ao);
    checks++; if ({a, ao} !== 2'b01) begin errors++; $display("FAIL wr_d1_ack got %b%b exp 01", a, ao); end
    i2c_stop();
    #(4*Q);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b exp 0", busy); end
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL wr_strobe_cnt got %0d exp 2", wlog.size()); end
    else begin
      checks++; if (wlog[0] !== 12'h35A) begin errors++; $display("FAIL wr_strobe0 got %h exp 35a", wlog[0]); end
      checks++; if (wlog[1] !== 12'h4C3) begin errors++; $display("FAIL wr_strobe1 got %h exp 4c3", wlog[1]); end
    end
  endtask

  task automatic test_read;
    logic a, ao;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, a, ao);
    write_byte(8'h03, a, ao);
    i2c_start();
    write_byte(8'hA1, a, ao);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b exp 0", a); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rd_byte0 got %h exp 5a", d); end
    read_byte(1'b0, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd_byte1 got %h exp c3", d); end
    #Q;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rd_nack_sda got %b exp 1", sda); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_nack_busy got %b exp 0", busy); end
    i2c_stop();
    #(4*Q);
  endtask

  task automatic test_bad_addr;
    logic a, ao;
    wlog.delete();
    i2c_start();
    write_byte(8'hA2, a, ao);
    checks++; if ({a, ao} !== 2'b10) begin errors++; $display("FAIL bad_addr_ack got %b%b exp 10", a, ao); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy got %b exp 0", busy); end
    write_byte(8'h11, a, ao);
    i2c_stop();
    #(4*Q);
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL bad_addr_strobe got %0d exp 0", wlog.size()); end
  endtask

  task automatic test_wrap;
    logic a, ao;
    logic [7:0] d;
    wlog.delete();
    i2c_start();
    write_byte(8'hA0, a, ao);
    write_byte(8'h0F, a, ao);
    write_byte(8'h11, a, ao);
    write_byte(8'h22, a, ao);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrap_ack got %b exp 0", a); end
    i2c_stop();
    #(4*Q);
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL wrap_strobe_cnt got %0d exp 2", wlog.size()); end
    else begin
      checks++; if (wlog[0] !== 12'hF11) begin errors++; $display("FAIL wrap_strobe0 got %h exp f11", wlog[0]); end
      checks++; if (wlog[1] !== 12'h022) begin errors++; $display("FAIL wrap_strobe1 got %h exp 022", wlog[1]); end
    end
    i2c_start();
    write_byte(8'hA0, a, ao);
    write_byte(8'h0F, a, ao);
    i2c_start();
    write_byte(8'hA1, a, ao);
    read_byte(1'b1, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL wrap_rd0 got %h exp 11", d); end
    read_byte(1'b0, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL wrap_rd1 got %h exp 22", d); end
    i2c_stop();
    #(4*Q);
  endtask

  task automatic test_gcall;
    logic a, ao;
    logic [7:0] d;
    wlog.delete();
    i2c_start();
    write_byte(8'h00, a, ao);
`ifdef I2C_SLAVE_GCALL_EN
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL gcall_ack got %b exp 0", a); end
`else
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL gcall_ack got %b exp 1", a); end
`endif
    write_byte(8'h77, a, ao);
    i2c_stop();
    #(4*Q);
`ifdef I2C_SLAVE_GCALL_EN
    checks++; if (wlog.size() != 1 || wlog[0] !== 12'h077)
      begin errors++; $display("FAIL gcall_strobe got n=%0d exp one 077", wlog.size()); end
`else
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL gcall_strobe got %0d exp 0", wlog.size()); end
`endif
    i2c_start();
    write_byte(8'hA0, a, ao);
    write_byte(8'h00, a, ao);
    i2c_start();
    write_byte(8'hA1, a, ao);
    read_byte(1'b0, d);
`ifdef I2C_SLAVE_GCALL_EN
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL gcall_mem0 got %h exp 77", d); end
`else
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL gcall_mem0 got %h exp 22", d); end
`endif
    i2c_stop();
    #(4*Q);
  endtask

  task automatic test_reset_mid;
    logic a, ao;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, a, ao);
    write_byte(8'h03, a, ao);
    i2c_start();
    write_byte(8'hA1, a, ao);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rstmid_drive got %b exp 0", sda); end
    rst = 1'b1;
    #1;
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda got %b exp 1", sda); end
    checks++; if ({busy, ack_out} !== 2'b00) begin errors++; $display("FAIL rstmid_busy got %b%b exp 00", busy, ack_out); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_low = 1'b0; scl = 1'b1;
    #(4*Q);
    i2c_start();
    write_byte(8'hA0, a, ao);
    write_byte(8'h03, a, ao);
    i2c_start();
    write_byte(8'hA1, a, ao);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL rstmid_addr_ack got %b exp 0", a); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_mem3 got %h exp 00", d); end
    read_byte(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_mem4 got %h exp 00", d); end
    i2c_stop();
    #(4*Q);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_addr();
    test_wrap();
    test_gcall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
